// File: rtl/mem_adapter_4b_16b.sv
// Word-to-line memory adapter: turns 4 B requests into 16 B line reads and
// read-modify-write line updates against a 128-bit wide memory.
package mem_adapter_pkg;
  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;
endpackage

module mem_adapter_4b_16b
  import mem_adapter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  mem_req_4B_t   cpu_req_msg,
  input  logic          cpu_req_val,
  output logic          cpu_req_rdy,
  output mem_resp_4B_t  cpu_resp_msg,
  output logic          cpu_resp_val,
  input  logic          cpu_resp_rdy,
  output mem_req_16B_t  mem_req_msg,
  output logic          mem_req_val,
  input  logic          mem_req_rdy,
  input  mem_resp_16B_t mem_resp_msg,
  input  logic          mem_resp_val,
  output logic          mem_resp_rdy
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_t;

  state_t       state, state_nxt;
  logic [2:0]   r_type;
  logic [7:0]   r_opaque;
  logic [31:0]  r_addr;
  logic [1:0]   r_len;
  logic [31:0]  r_data;
  logic [127:0] r_line;

  logic         cpu_req_hs;
  logic [2:0]   cnt;
  logic [1:0]   off, wsel;
  logic [2:0]   bpos;
  logic [31:0]  sel_word, rd_word;
  logic [127:0] wr_line;

  assign cpu_req_rdy = (state == IDLE) && !rst;
  assign cpu_req_hs  = cpu_req_val && cpu_req_rdy;

  assign cnt  = (r_len == 2'd0) ? 3'd4 : {1'b0, r_len};
  assign off  = r_addr[1:0];
  assign wsel = r_addr[3:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type   <= '0;
      r_opaque <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_data   <= '0;
      r_line   <= '0;
    end else begin
      if (cpu_req_hs) begin
        r_type   <= cpu_req_msg.type_;
        r_opaque <= cpu_req_msg.opaque;
        r_addr   <= cpu_req_msg.addr;
        r_len    <= cpu_req_msg.len;
        r_data   <= cpu_req_msg.data;
      end
      if (state == RD_WAIT && mem_resp_val) r_line <= mem_resp_msg.data;
    end
  end

  // Byte lanes that would run past the selected word are dropped on both paths.
  always_comb begin
    wr_line  = r_line;
    rd_word  = '0;
    bpos     = '0;
    sel_word = r_line[{wsel, 5'b00000} +: 32];
    for (int i = 0; i < 4; i++) begin
      bpos = {1'b0, off} + 3'(i);
      if (3'(i) < cnt && !bpos[2]) begin
        wr_line[{wsel, bpos[1:0], 3'b000} +: 8] = r_data[i*8 +: 8];
        rd_word[i*8 +: 8] = sel_word[{bpos[1:0], 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_req_val  = 1'b0;
    mem_req_msg  = '0;
    mem_resp_rdy = 1'b0;
    cpu_resp_val = 1'b0;
    cpu_resp_msg = '0;
    case (state)
      IDLE: if (cpu_req_hs) state_nxt = RD_REQ;
      RD_REQ: begin
        mem_req_val       = 1'b1;
        mem_req_msg.type_ = MEM_READ;
        mem_req_msg.addr  = {r_addr[31:4], 4'h0};
        if (mem_req_rdy) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) state_nxt = (r_type == MEM_WRITE) ? WR_REQ : RESP;
      end
      WR_REQ: begin
        mem_req_val       = 1'b1;
        mem_req_msg.type_ = MEM_WRITE;
        mem_req_msg.addr  = {r_addr[31:4], 4'h0};
        mem_req_msg.data  = wr_line;
        if (mem_req_rdy) state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) state_nxt = RESP;
      end
      RESP: begin
        cpu_resp_val        = 1'b1;
        cpu_resp_msg.type_  = r_type;
        cpu_resp_msg.opaque = r_opaque;
        cpu_resp_msg.len    = r_len;
        cpu_resp_msg.data   = (r_type == MEM_WRITE) ? 32'h0 : rd_word;
        if (cpu_resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_adapter_4b_16b.sv
// Bench for mem_adapter_4b_16b: vector table of word transactions against a
// line-memory model, plus backpressure and mid-transaction reset sequences.
module tb_mem_adapter_4b_16b;
  import mem_adapter_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  mem_req_4B_t   cpu_req_msg = '0;
  logic          cpu_req_val = 1'b0;
  logic          cpu_req_rdy;
  mem_resp_4B_t  cpu_resp_msg;
  logic          cpu_resp_val;
  logic          cpu_resp_rdy = 1'b1;
  mem_req_16B_t  mem_req_msg;
  logic          mem_req_val;
  logic          mem_req_rdy = 1'b1;
  mem_resp_16B_t mem_resp_msg = '0;
  logic          mem_resp_val = 1'b0;
  logic          mem_resp_rdy;

  always #5 clk = ~clk;

  mem_adapter_4b_16b dut (
    .clk(clk), .rst(rst),
    .cpu_req_msg(cpu_req_msg), .cpu_req_val(cpu_req_val), .cpu_req_rdy(cpu_req_rdy),
    .cpu_resp_msg(cpu_resp_msg), .cpu_resp_val(cpu_resp_val), .cpu_resp_rdy(cpu_resp_rdy),
    .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  mem_resp_4B_t exp_resp_q[$];
  logic [127:0] exp_wr_q[$];
  logic [31:0]  exp_line_addr = '0;

  // Line memory: one-cycle response after each accepted request.
  logic [127:0] mem [logic [27:0]];
  logic         req_hs_d = 1'b0, resp_hs_d = 1'b0, pend = 1'b0;
  logic         mem_hold = 1'b0, mem_kill = 1'b0;
  mem_req_16B_t req_d = '0;
  logic [127:0] resp_data = '0;

  always begin
    @(negedge clk); #1;
    if (resp_hs_d) mem_resp_val = 1'b0;
    if (req_hs_d) begin
      check("mem_req_addr", 192'(req_d.addr), 192'(exp_line_addr));
      check("mem_req_len_opaque", 192'({req_d.opaque, req_d.len}), 192'(0));
      if (req_d.type_ == MEM_WRITE) begin
        if (exp_wr_q.size() == 0) begin
          n_chk++;
          $display("FAIL mem_wr_unexpected: got write %0h expected none", req_d.data);
        end else check("mem_wr_line", 192'(req_d.data), 192'(exp_wr_q.pop_front()));
        mem[req_d.addr[31:4]] = req_d.data;
        resp_data = {4{32'hBADC0FFE}};
      end else begin
        resp_data = mem.exists(req_d.addr[31:4]) ? mem[req_d.addr[31:4]] : 128'h0;
      end
      pend = 1'b1;
    end
    if (mem_kill) begin
      pend = 1'b0;
      mem_resp_val = 1'b0;
    end
    if (pend && !mem_hold) begin
      mem_resp_val = 1'b1;
      mem_resp_msg = '{type_:req_d.type_, opaque:8'h0, test:2'h0, len:4'h0, data:resp_data};
      pend = 1'b0;
    end
    req_hs_d  = mem_req_val && mem_req_rdy && !rst;
    resp_hs_d = mem_resp_val && mem_resp_rdy && !rst;
    if (req_hs_d) req_d = mem_req_msg;
  end

  typedef struct {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [1:0]   l;
    logic [31:0]  d;
    logic [7:0]   op;
    logic [31:0]  exp_d;
    logic [127:0] exp_line;
    int           lat;
  } vec_t;

  vec_t tbl[12];

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_txn(input vec_t v, input int mem_stall, input int resp_stall);
    mem_resp_4B_t exp, got0;
    mem_req_16B_t held;
    int cyc, stalled;
    bit seen;
    exp = '{type_:v.t, opaque:v.op, test:2'd0, len:v.l, data:(v.t == MEM_WRITE) ? 32'h0 : v.exp_d};
    exp_resp_q.push_back(exp);
    if (v.t == MEM_WRITE) exp_wr_q.push_back(v.exp_line);
    exp_line_addr = {v.a[31:4], 4'h0};
    mem_req_rdy  = (mem_stall == 0);
    cpu_resp_rdy = (resp_stall == 0);
    check("cpu_req_rdy_idle", 192'(cpu_req_rdy), 192'(1));
    cpu_req_msg = '{type_:v.t, opaque:v.op, addr:v.a, len:v.l, data:v.d};
    cpu_req_val = 1'b1;
    @(negedge clk);
    // A competing request held valid while busy must be ignored.
    cpu_req_msg = '{type_:MEM_WRITE, opaque:8'hEE, addr:32'h0000_0FF0, len:2'd0, data:32'hFFFF_FFFF};
    cyc = 1; stalled = 0; seen = 0; held = '0;
    while (!cpu_resp_val && cyc < 40) begin
      check("cpu_req_rdy_busy", 192'(cpu_req_rdy), 192'(0));
      if (mem_req_val && !mem_req_rdy) begin
        if (!seen) begin held = mem_req_msg; seen = 1; end
        else check("mem_req_stable", 192'(mem_req_msg), 192'(held));
        stalled++;
        if (stalled >= mem_stall) mem_req_rdy = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!cpu_resp_val) begin
      n_chk++;
      $display("FAIL resp_timeout: got no cpu_resp_val after %0d cycles, expected one", cyc);
      cpu_req_val = 1'b0;
      cpu_resp_rdy = 1'b1;
      mem_req_rdy = 1'b1;
      void'(exp_resp_q.pop_front());
    end else begin
      if (v.lat > 0) check("latency", 192'(cyc), 192'(v.lat));
      got0 = cpu_resp_msg;
      for (int k = 0; k < resp_stall; k++) begin
        check("resp_val_hold", 192'(cpu_resp_val), 192'(1));
        check("resp_msg_stable", 192'(cpu_resp_msg), 192'(got0));
        check("cpu_req_rdy_resp", 192'(cpu_req_rdy), 192'(0));
        @(negedge clk);
      end
      cpu_resp_rdy = 1'b1;
      cpu_req_val  = 1'b0;
      exp = exp_resp_q.pop_front();
      check("resp_type", 192'(cpu_resp_msg.type_), 192'(exp.type_));
      check("resp_opaque", 192'(cpu_resp_msg.opaque), 192'(exp.opaque));
      check("resp_test_len", 192'({cpu_resp_msg.test, cpu_resp_msg.len}), 192'({exp.test, exp.len}));
      check("resp_data", 192'(cpu_resp_msg.data), 192'(exp.data));
      @(negedge clk);
      check("back_to_idle", 192'({cpu_resp_val, cpu_req_rdy}), 192'(2'b01));
    end
    mem_req_rdy = 1'b1;
  endtask

  initial begin
    vec_t v;
    int guard;
    tbl[0]  = '{MEM_READ,  32'h108, 2'd0, 32'h0,        8'h11, 32'h22222222, 128'h0, 3};
    tbl[1]  = '{MEM_WRITE, 32'h105, 2'd1, 32'h000000AB, 8'h22, 32'h0,
                128'h33333333_22222222_1111AB11_00000000, 5};
    tbl[2]  = '{MEM_READ,  32'h10A, 2'd2, 32'h0,        8'h33, 32'h00002222, 128'h0, 3};
    tbl[3]  = '{MEM_READ,  32'h104, 2'd0, 32'h0,        8'h44, 32'h1111AB11, 128'h0, 3};
    tbl[4]  = '{MEM_READ,  32'h105, 2'd3, 32'h0,        8'h55, 32'h001111AB, 128'h0, 3};
    tbl[5]  = '{MEM_WRITE, 32'h10F, 2'd3, 32'h00CCBBAA, 8'h66, 32'h0,
                128'hAA333333_22222222_1111AB11_00000000, 5};
    tbl[6]  = '{MEM_READ,  32'h110, 2'd0, 32'h0,        8'h77, 32'h44444444, 128'h0, 3};
    tbl[7]  = '{MEM_READ,  32'h10C, 2'd0, 32'h0,        8'h88, 32'hAA333333, 128'h0, 3};
    tbl[8]  = '{MEM_WRITE, 32'h112, 2'd2, 32'h1234BEEF, 8'h99, 32'h0,
                128'h77777777_66666666_55555555_BEEF4444, 5};
    tbl[9]  = '{MEM_READ,  32'h110, 2'd0, 32'h0,        8'hAA, 32'hBEEF4444, 128'h0, 3};
    tbl[10] = '{MEM_WRITE, 32'h118, 2'd0, 32'hDEADBEEF, 8'hBB, 32'h0,
                128'h77777777_DEADBEEF_55555555_BEEF4444, 5};
    tbl[11] = '{MEM_READ,  32'h11B, 2'd1, 32'h0,        8'hCC, 32'h000000DE, 128'h0, 3};

    mem[28'h10] = 128'h33333333_22222222_11111111_00000000;
    mem[28'h11] = 128'h77777777_66666666_55555555_44444444;

    repeat (2) @(negedge clk);
    check("rst_rdy_flags", 192'({cpu_req_rdy, cpu_resp_val, mem_req_val, mem_resp_rdy}), 192'(0));
    check("rst_cpu_resp_msg", 192'(cpu_resp_msg), 192'(0));
    check("rst_mem_req_msg", 192'(mem_req_msg), 192'(0));
    rst = 1'b0;
    #1 check("cpu_req_rdy_after_rst", 192'(cpu_req_rdy), 192'(1));
    @(negedge clk);

    for (int i = 0; i < 12; i++) do_txn(tbl[i], 0, 0);

    // Backpressure on both sides.
    v = '{MEM_READ, 32'h118, 2'd0, 32'h0, 8'h5C, 32'hDEADBEEF, 128'h0, 0};
    do_txn(v, 4, 3);
    v = '{MEM_WRITE, 32'h100, 2'd0, 32'h0BADF00D, 8'h6D, 32'h0,
          128'hAA333333_22222222_1111AB11_0BADF00D, 0};
    do_txn(v, 2, 1);

    // Reset while waiting on the write response.
    exp_line_addr = 32'h100;
    exp_wr_q.push_back(128'hAA333333_22222222_CAFEF00D_0BADF00D);
    cpu_req_msg = '{type_:MEM_WRITE, opaque:8'h7E, addr:32'h104, len:2'd0, data:32'hCAFEF00D};
    cpu_req_val = 1'b1;
    @(negedge clk);
    cpu_req_val = 1'b0;
    guard = 0;
    while (!(mem_req_val && mem_req_msg.type_ == MEM_WRITE) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("reached_wr_req", 192'(mem_req_val), 192'(1));
    mem_hold = 1'b1;
    @(negedge clk);
    check("in_wr_wait", 192'({mem_resp_rdy, mem_req_val, cpu_resp_val}), 192'(3'b100));
    #2 rst = 1'b1;
    #1 check("async_rst_flags", 192'({cpu_req_rdy, cpu_resp_val, mem_req_val, mem_resp_rdy}), 192'(0));
    check("async_rst_msgs", 192'({cpu_resp_msg, mem_req_msg}), 192'(0));
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;
    #1 check("rdy_after_mid_rst", 192'(cpu_req_rdy), 192'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stale_resp_present", 192'(mem_resp_val), 192'(1));
      check("stale_resp_ignored", 192'({cpu_req_rdy, cpu_resp_val, mem_req_val, mem_resp_rdy}), 192'(4'b1000));
    end
    mem_kill = 1'b1;
    @(negedge clk);
    mem_kill = 1'b0;
    @(negedge clk);

    v = '{MEM_READ, 32'h104, 2'd0, 32'h0, 8'h3F, 32'hCAFEF00D, 128'h0, 3};
    do_txn(v, 0, 0);
    check("scoreboard_empty", 192'(exp_resp_q.size() + exp_wr_q.size()), 192'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
